// File: rtl/spi_cmd_seq.sv
// rtl/spi_cmd_seq.sv - SPI register command sequencer (op, addr, wdata / read bytes)
//
// Turns one register command into a byte sequence for a full-duplex SPI byte
// driver, one byte in flight at a time, and streams returned read bytes.
//   i_clk, i_rst             clock, asynchronous active-high reset
//   i_cmd_*, o_cmd_ready     command request (wr, op, addr, wdata, rlen)
//   o_drv_data/valid, i_drv_ready      byte out to the driver
//   i_drv_rdata, i_drv_rvalid          byte back from the driver (1-cycle strobe)
//   o_rd_data/valid/last     read stream, no backpressure
//   o_busy, o_done, o_err    status, completion pulse, watchdog-abort pulse

module spi_cmd_seq #(
    parameter int P_DATA_WIDTH = 8,
    parameter int P_TIMEOUT    = 1024
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_cmd_valid,
    output logic                    o_cmd_ready,
    input  logic                    i_cmd_wr,
    input  logic [P_DATA_WIDTH-1:0] i_cmd_op,
    input  logic [P_DATA_WIDTH-1:0] i_cmd_addr,
    input  logic [P_DATA_WIDTH-1:0] i_cmd_wdata,
    input  logic [3:0]              i_cmd_rlen,
    output logic [P_DATA_WIDTH-1:0] o_drv_data,
    output logic                    o_drv_valid,
    input  logic                    i_drv_ready,
    input  logic [P_DATA_WIDTH-1:0] i_drv_rdata,
    input  logic                    i_drv_rvalid,
    output logic [P_DATA_WIDTH-1:0] o_rd_data,
    output logic                    o_rd_valid,
    output logic                    o_rd_last,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_DONE
    } state_t;

    localparam int             WD_W    = (P_TIMEOUT > 1) ? $clog2(P_TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(P_TIMEOUT - 1);

    state_t                  state_q, state_nx;
    logic                    cmd_wr_q;
    logic [P_DATA_WIDTH-1:0] op_q, addr_q, wdata_q;
    logic [3:0]              rlen_q;
    logic [4:0]              cnt_q;       // index of the byte currently in flight
    logic [WD_W-1:0]         wdog_q;
    logic                    cmd_ready_q;
    logic [P_DATA_WIDTH-1:0] rd_data_q;
    logic                    rd_valid_q, rd_last_q, err_q;

    logic                    accept, timeout, rx_fire, rd_fire;
    logic                    last_byte, wd_expired;
    logic [4:0]              last_idx;
    logic [P_DATA_WIDTH-1:0] drv_byte;

    assign accept     = i_cmd_valid && cmd_ready_q;
    assign last_idx   = cmd_wr_q ? 5'd2 : (5'd1 + {1'b0, rlen_q});
    assign last_byte  = (cnt_q == last_idx);
    assign wd_expired = (wdog_q == WD_LAST);
    // Bytes 0 and 1 are op/addr; only a read's later bytes carry data back.
    assign rd_fire    = rx_fire && !cmd_wr_q && (cnt_q >= 5'd2);

    always_comb begin
        state_nx = state_q;
        timeout  = 1'b0;
        rx_fire  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) state_nx = S_SEND;
            end
            S_SEND: begin
                // A handshake landing on the last watchdog cycle still wins.
                if (i_drv_ready) begin
                    state_nx = S_WAIT;
                end else if (wd_expired) begin
                    state_nx = S_IDLE;
                    timeout  = 1'b1;
                end
            end
            S_WAIT: begin
                if (i_drv_rvalid) begin
                    rx_fire  = 1'b1;
                    state_nx = last_byte ? S_DONE : S_SEND;
                end else if (wd_expired) begin
                    state_nx = S_IDLE;
                    timeout  = 1'b1;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        drv_byte = '0;
        if (state_q == S_SEND) begin
            case (cnt_q)
                5'd0:    drv_byte = op_q;
                5'd1:    drv_byte = addr_q;
                default: drv_byte = cmd_wr_q ? wdata_q : '0;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            cmd_wr_q    <= 1'b0;
            op_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rlen_q      <= '0;
            cnt_q       <= '0;
            wdog_q      <= '0;
            cmd_ready_q <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_nx;
            // Registered so ready stays low through reset and rises one edge later.
            cmd_ready_q <= (state_nx == S_IDLE);

            if (accept) begin
                cmd_wr_q <= i_cmd_wr;
                op_q     <= i_cmd_op;
                addr_q   <= i_cmd_addr;
                wdata_q  <= i_cmd_wdata;
                rlen_q   <= i_cmd_rlen;
                cnt_q    <= '0;
            end else if (rx_fire) begin
                cnt_q <= cnt_q + 5'd1;
            end

            // Every state change restarts the watchdog for the new handshake.
            if (state_nx != state_q) begin
                wdog_q <= '0;
            end else if (state_q == S_SEND || state_q == S_WAIT) begin
                wdog_q <= wdog_q + 1'b1;
            end

            rd_valid_q <= rd_fire;
            rd_last_q  <= rd_fire && last_byte;
            if (rd_fire) rd_data_q <= i_drv_rdata;
            err_q      <= timeout;
        end
    end

    assign o_cmd_ready = cmd_ready_q;
    assign o_drv_data  = drv_byte;
    assign o_drv_valid = (state_q == S_SEND);
    assign o_rd_data   = rd_data_q;
    assign o_rd_valid  = rd_valid_q;
    assign o_rd_last   = rd_last_q;
    assign o_busy      = (state_q != S_IDLE);
    assign o_done      = (state_q == S_DONE);
    assign o_err       = err_q;

endmodule
